// File: rtl/ssi_read_ctrl.sv
// SSI absolute-encoder read controller.
// On an accepted start request, drives DATA_WIDTH+1 ssi_clk periods. The first
// falling edge latches the encoder position. Each later falling edge samples
// one bit, MSB first. The word is Gray-decoded when GRAY_CODE=1. A monoflop
// recovery interval, with ssi_clk held high, follows every read.
module ssi_read_ctrl #(
    parameter int DATA_WIDTH      = 13,
    parameter int CLK_DIV         = 10,
    parameter int MONOFLOP_CYCLES = 250,
    parameter int GRAY_CODE       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  ssi_data,
    output logic                  ssi_clk,
    output logic [DATA_WIDTH-1:0] position,
    output logic                  valid,
    output logic                  busy,
    output logic                  line_err
);

    localparam int DIV_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam int MONO_W = (MONOFLOP_CYCLES > 1) ? $clog2(MONOFLOP_CYCLES) : 1;

    // Divider phase where ssi_clk must rise next cycle, and last phase of a period.
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH);
    localparam logic [MONO_W-1:0] MONO_LAST = MONO_W'(MONOFLOP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LATCH    = 2'd1,
        SHIFT    = 2'd2,
        MONOFLOP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic                    ssi_data_s;
    logic                    ssi_clk_q, ssi_clk_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [MONO_W-1:0]       mono_q, mono_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   position_q, position_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    line_err_q, line_err_d;
    logic                    last_rise;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [DATA_WIDTH-1:0] gray2bin(input logic [DATA_WIDTH-1:0] g);
        logic [DATA_WIDTH-1:0] b;
        b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
        for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] decode(input logic [DATA_WIDTH-1:0] w);
        return (GRAY_CODE != 0) ? gray2bin(w) : w;
    endfunction

    assign ssi_data_s = sync2_q;

    // The cycle in which ssi_clk must rise for the last time.
    assign last_rise = (state_q == SHIFT) && (bit_q == BIT_LAST) && (div_q == DIV_HALF);

    // Two-flop synchronizer for the asynchronous encoder data line; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ssi_data;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && ssi_data_s) state_d = LATCH;
            LATCH:    if (div_q == DIV_LAST) state_d = SHIFT;
            SHIFT:    if (last_rise) state_d = MONOFLOP;
            MONOFLOP: if (mono_q == MONO_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Clock generation, bit sampling, decode and strobes for the next cycle.
    always_comb begin
        ssi_clk_d  = ssi_clk_q;
        div_d      = div_q;
        bit_d      = bit_q;
        mono_d     = mono_q;
        shift_d    = shift_q;
        position_d = position_q;
        valid_d    = 1'b0;
        line_err_d = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                ssi_clk_d = 1'b1;
                div_d     = '0;
                bit_d     = '0;
                mono_d    = '0;
                if (start) begin
                    if (ssi_data_s) begin
                        ssi_clk_d = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        line_err_d = 1'b1;
                    end
                end
            end
            LATCH, SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    bit_d     = bit_q + 1'b1;
                    ssi_clk_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
                if (div_q == DIV_HALF) begin
                    ssi_clk_d = 1'b1;
                end
                // Phase 0 is the cycle in which ssi_clk was just driven low.
                if ((state_q == SHIFT) && (div_q == '0)) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], ssi_data_s};
                end
                if (last_rise) begin
                    position_d = decode(shift_q);
                    valid_d    = 1'b1;
                    div_d      = '0;
                    mono_d     = '0;
                end
            end
            MONOFLOP: begin
                ssi_clk_d = 1'b1;
                if (mono_q == MONO_LAST) begin
                    busy_d = 1'b0;
                    mono_d = '0;
                end else begin
                    mono_d = mono_q + 1'b1;
                end
            end
            default: begin
                ssi_clk_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ssi_clk_q  <= 1'b1;
            div_q      <= '0;
            bit_q      <= '0;
            mono_q     <= '0;
            shift_q    <= '0;
            position_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            ssi_clk_q  <= ssi_clk_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            mono_q     <= mono_d;
            shift_q    <= shift_d;
            position_q <= position_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            line_err_q <= line_err_d;
        end
    end

    assign ssi_clk  = ssi_clk_q;
    assign position = position_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign line_err = line_err_q;

endmodule

// File: tb/tb_ssi_read_ctrl.sv
// Bench for ssi_read_ctrl: behavioural SSI encoders, a position scoreboard,
// and directed timing and corner-case checks.
module tb_ssi_read_ctrl;

    localparam int DW = 13;
    localparam int CD = 4;
    localparam int MC = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic          hold_low = 1'b0;

    logic          ssi_clk_a, valid_a, busy_a, line_err_a, ssi_data_a;
    logic [DW-1:0] position_a;
    logic          ssi_clk_b, valid_b, busy_b, line_err_b;
    logic [DW-1:0] position_b;

    logic          enc_data_a = 1'b1;
    logic          enc_data_b = 1'b1;
    logic [DW-1:0] enc_word_a = '0, enc_word_b = '0;
    logic [DW-1:0] enc_sreg_a, enc_sreg_b;
    int            enc_idx_a, enc_idx_b;
    bit            enc_act_a = 1'b0, enc_act_b = 1'b0;
    int            falls_a = 0;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;

    typedef struct {
        logic [DW-1:0] pos;
        int            at;
    } exp_t;
    exp_t sb[$];

    assign ssi_data_a = hold_low ? 1'b0 : enc_data_a;

    ssi_read_ctrl #(
        .DATA_WIDTH(DW), .CLK_DIV(CD), .MONOFLOP_CYCLES(MC), .GRAY_CODE(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start_a), .ssi_data(ssi_data_a),
        .ssi_clk(ssi_clk_a), .position(position_a), .valid(valid_a),
        .busy(busy_a), .line_err(line_err_a)
    );

    ssi_read_ctrl #(
        .DATA_WIDTH(DW), .CLK_DIV(CD), .MONOFLOP_CYCLES(MC), .GRAY_CODE(0)
    ) dut_bin (
        .clk(clk), .reset(reset), .start(start_b), .ssi_data(enc_data_b),
        .ssi_clk(ssi_clk_b), .position(position_b), .valid(valid_b),
        .busy(busy_b), .line_err(line_err_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Encoder A: latch on first falling edge, present next bit (MSB first) on each rising edge.
    always @(negedge ssi_clk_a) begin
        falls_a = falls_a + 1;
        if (!enc_act_a) begin
            enc_act_a  = 1'b1;
            enc_sreg_a = enc_word_a;
            enc_idx_a  = DW;
        end
    end

    always @(posedge ssi_clk_a) begin
        if (enc_act_a) begin
            if (enc_idx_a > 0) begin
                enc_idx_a  = enc_idx_a - 1;
                enc_data_a = enc_sreg_a[enc_idx_a];
            end else begin
                enc_data_a = 1'b1;
                enc_act_a  = 1'b0;
            end
        end
    end

    // Encoder B, same behaviour.
    always @(negedge ssi_clk_b) begin
        if (!enc_act_b) begin
            enc_act_b  = 1'b1;
            enc_sreg_b = enc_word_b;
            enc_idx_b  = DW;
        end
    end

    always @(posedge ssi_clk_b) begin
        if (enc_act_b) begin
            if (enc_idx_b > 0) begin
                enc_idx_b  = enc_idx_b - 1;
                enc_data_b = enc_sreg_b[enc_idx_b];
            end else begin
                enc_data_b = 1'b1;
                enc_act_b  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every valid strobe pops one expected position and cycle.
    logic prev_vld = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (prev_vld) chk("valid_width", {31'd0, valid_a}, 32'd0);
        if (valid_a === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'd0, valid_a}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("position", {19'd0, position_a}, {19'd0, e.pos});
                chk("valid_cycle", cyc, e.at);
            end
        end
        prev_vld = valid_a;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; start is high for exactly the current cycle.
    task automatic pulse_start(output int ts);
        start_a = 1'b1;
        ts      = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_idle(output int tf);
        int k = 0;
        while (busy_a !== 1'b0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        tf = cyc;
        if (k >= 400) chk("idle_timeout", {31'd0, busy_a}, 32'd0);
    endtask

    task automatic read_b(input logic [DW-1:0] w);
        int k = 0;
        enc_word_b = w;
        start_b    = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (valid_b !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("bin_timeout", {31'd0, valid_b}, 32'd1);
        else          chk("bin_position", {19'd0, position_b}, {19'd0, w});
        k = 0;
        while (busy_b !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("bin_idle_timeout", {31'd0, busy_b}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int ts, ts2, tf;

        // Reset state
        tick(3);
        chk("rst_ssi_clk", {31'd0, ssi_clk_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_line_err", {31'd0, line_err_a}, 32'd0);
        chk("rst_position", {19'd0, position_a}, 32'd0);
        reset = 1'b0;
        tick(4);

        // Reset in the middle of a read aborts it without a strobe
        enc_word_a = 13'h0007;
        pulse_start(ts);
        while (cyc < ts + 60) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ssi_clk", {31'd0, ssi_clk_a}, 32'd1);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        enc_act_a  = 1'b0;
        enc_data_a = 1'b1;
        tick(150);
        chk("abort_position", {19'd0, position_a}, 32'd0);

        // Reset and start together: reset wins
        reset   = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        start_a = 1'b0;
        chk("rst_start_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_start_clk", {31'd0, ssi_clk_a}, 32'd1);
        tick(4);

        // Gray 0x0007 -> 5, exact timing
        enc_word_a = 13'h0007;
        falls_a    = 0;
        pulse_start(ts);
        sb.push_back('{pos: 13'd5, at: ts + 109});
        chk("start_busy", {31'd0, busy_a}, 32'd1);
        chk("start_ssi_clk", {31'd0, ssi_clk_a}, 32'd0);
        wait_idle(tf);
        chk("busy_fall", tf, ts + 129);
        chk("falling_edges", falls_a, 32'd14);

        // Back-to-back reads, second start in the first idle cycle
        enc_word_a = 13'h1FFF;
        pulse_start(ts);
        sb.push_back('{pos: 13'h1555, at: ts + 109});
        chk("accept_first_idle", {31'd0, busy_a}, 32'd1);
        wait_idle(tf);
        enc_word_a = 13'h1000;
        pulse_start(ts);
        sb.push_back('{pos: 13'h1FFF, at: ts + 109});
        wait_idle(tf);

        // Start during a read is ignored; start after the read is accepted
        enc_word_a = 13'h0002;
        falls_a    = 0;
        pulse_start(ts);
        sb.push_back('{pos: 13'd3, at: ts + 109});
        while (cyc < ts + 50) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(tf);
        chk("ignored_falls", falls_a, 32'd14);
        chk("ignored_busy_fall", tf, ts + 129);
        @(negedge clk);
        enc_word_a = 13'h0003;
        pulse_start(ts2);
        sb.push_back('{pos: 13'd2, at: ts2 + 109});
        chk("restart_busy", {31'd0, busy_a}, 32'd1);
        wait_idle(tf);

        // Data line held low: start rejected with a one-cycle line_err
        hold_low = 1'b1;
        tick(4);
        falls_a = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("line_err_set", {31'd0, line_err_a}, 32'd1);
        chk("line_err_busy", {31'd0, busy_a}, 32'd0);
        @(negedge clk);
        chk("line_err_clear", {31'd0, line_err_a}, 32'd0);
        tick(20);
        chk("line_err_no_clk", falls_a, 32'd0);
        chk("line_err_busy_after", {31'd0, busy_a}, 32'd0);
        hold_low = 1'b0;
        tick(4);

        // Binary pass-through instance, bit order MSB first
        read_b(13'h1A5B);
        read_b(13'h0001);
        read_b(13'h1000);

        tick(5);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ssi_read_ctrl.md
SSI_READ_CTRL -- requirements
Module: ssi_read_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 13: encoder position word width in bits, legal range 2..32.
REQ-002 Parameter CLK_DIV, default 10: ssi_clk half-period in clk cycles, minimum 4.
REQ-003 Parameter MONOFLOP_CYCLES, default 250: post-transfer recovery time in clk cycles with ssi_clk held high, minimum 1.
REQ-004 Parameter GRAY_CODE, default 1: 1 = received word is Gray and is converted to binary; 0 = word passes through unchanged.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle read request from the upstream debounced pulse generator.
REQ-008 ssi_data  input  1  encoder serial data, asynchronous to clk; idles high.
REQ-009 ssi_clk  output  1  SSI clock to encoder, registered; idles high.
REQ-010 position  output  DATA_WIDTH  last decoded position, held between reads.
REQ-011 valid  output  1  one-cycle strobe marking a new position value.
REQ-012 busy  output  1  high from start acceptance until monoflop time expires.
REQ-013 line_err  output  1  one-cycle strobe: start rejected because ssi_data was low.

Function
REQ-014 ssi_data passes through a 2-flop synchronizer; all uses of ssi_data refer to the synchronized value (ssi_data_s).
REQ-015 States: IDLE, LATCH (first clock period, no data), SHIFT, MONOFLOP.
REQ-016 IDLE: start=1 and ssi_data_s=1 -> LATCH, with busy=1 and ssi_clk=0 from the next cycle (cycle t+1 for start at cycle t).
REQ-017 IDLE: start=1 and ssi_data_s=0 -> remain in IDLE, line_err=1 for the next cycle only, ssi_clk stays high.
REQ-018 start while busy=1 is ignored with no side effect; no request is queued.
REQ-019 Clock period: ssi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles; total DATA_WIDTH+1 periods per read.
REQ-020 Falling edge k (k=1..DATA_WIDTH+1) occurs at cycle t+1+(k-1)*2*CLK_DIV.
REQ-021 Falling edge 1 latches the encoder position and no bit is sampled (LATCH).
REQ-022 Falling edges 2..DATA_WIDTH+1: sample ssi_data_s in the cycle ssi_clk is driven 1->0 and shift it into the shift register; the first sampled bit is the MSB (SHIFT).
REQ-023 Final rising edge at cycle t+1+DATA_WIDTH*2*CLK_DIV+CLK_DIV; in that cycle position updates and valid=1 for one cycle; the state becomes MONOFLOP.
REQ-024 Gray decode (GRAY_CODE=1): bin[MSB]=g[MSB]; bin[i]=bin[i+1] XOR g[i] for lower bits, computed combinationally before the position register.
REQ-025 MONOFLOP: ssi_clk=1 for MONOFLOP_CYCLES cycles, then the state becomes IDLE and busy=0 in the same cycle.
REQ-026 A start arriving in the first IDLE cycle after MONOFLOP is accepted.
REQ-027 Internal bit and divider counters never wrap; they are sized for DATA_WIDTH+1 and 2*CLK_DIV respectively.

Reset
REQ-028 reset=1: state IDLE, ssi_clk=1, busy=0, valid=0, line_err=0, position=0, shift register and counters cleared, synchronizer flops set to 1.
REQ-029 reset asserted mid-transfer aborts the read with no valid strobe; the state is IDLE on the next cycle.
REQ-030 reset and start in the same cycle: reset wins and start is dropped.

Verification (DATA_WIDTH=13, CLK_DIV=4, MONOFLOP_CYCLES=20, GRAY_CODE=1)
REQ-031 Encoder model returns Gray 13'h0007, start at cycle t -> 14 falling edges of ssi_clk; position=13'd5 and valid=1 at cycle t+109 only; busy falls at t+129.
REQ-032 GRAY_CODE=0, encoder word 13'h1A5B -> position=13'h1A5B, with bit order MSB first confirmed.
REQ-033 ssi_data held low, start pulse -> line_err=1 for exactly 1 cycle; no ssi_clk activity; busy stays 0.
REQ-034 Second start at t+50 during a read -> ignored; exactly one valid strobe occurs; a start at t+130 begins a new read.
REQ-035 reset at t+60 mid-read -> ssi_clk=1, busy=0 the following cycle; no valid strobe; position retains reset value 0.
REQ-036 Back-to-back reads of Gray 13'h1FFF then 13'h1000 -> position 13'h1555 then 13'h1FFF, with each valid strobe exactly 1 cycle wide.
